// File: rtl/data_mem.sv
// data_mem: single-port 256 x 8 data memory for the lab processor.
//
// Reads are combinational from DataAddress. Writes are synchronous and
// byte-wide on the rising Clk edge when WriteEn is high. The asynchronous
// active-low Reset clears the whole array immediately and blocks writes
// while it is held low.
//
// The storage array is named Core and is intentionally left visible.
// Benches deposit into <inst>.Core[i] and read it back hierarchically.
// Only the reset and write paths below ever assign Core, so a deposited
// value persists until a write or a reset replaces it.
//
// Ports:
//   Clk          in   1  clock, writes on rising edge
//   Reset        in   1  asynchronous, active-low clear
//   WriteEn      in   1  write enable, sampled on rising Clk
//   DataAddress  in   A  word address for both read and write
//   DataIn       in   W  write data
//   DataOut      out  W  contents of Core[DataAddress]

module data_mem #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         WriteEn,
  input  logic [A-1:0] DataAddress,
  input  logic [W-1:0] DataIn,
  output logic [W-1:0] DataOut
);

  localparam int unsigned Depth = 2 ** A;

  logic [W-1:0] Core [Depth];

  // Reset wins over WriteEn. While Reset is low, every edge of Clk also
  // lands in the reset branch, so a pending write is discarded.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Core <= '{default: '0};
    end else if (WriteEn) begin
      Core[DataAddress] <= DataIn;
    end
  end

  // There is no read register and no write bypass. During a same-address
  // write, DataOut shows the old word until the edge and the new word
  // after it.
  assign DataOut = Core[DataAddress];

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;
  localparam int unsigned W     = 8;
  localparam int unsigned A     = 8;
  localparam int unsigned Depth = 256;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         WriteEn;
  logic [A-1:0] DataAddress;
  logic [W-1:0] DataIn;
  logic [W-1:0] DataOut;

  always #5 Clk = ~Clk;

  data_mem #(
    .W(W),
    .A(A)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .WriteEn    (WriteEn),
    .DataAddress(DataAddress),
    .DataIn     (DataIn),
    .DataOut    (DataOut)
  );

  // Reference contents: what every address must read, by definition.
  logic [W-1:0] model [Depth];
  int unsigned  n_checks = 0;
  int unsigned  n_fails  = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < Depth; i++) model[i] = '0;
  endtask

  task automatic read_at(input logic [A-1:0] addr, input string tag);
    DataAddress = addr;
    #1;
    check_eq(tag, DataOut, model[addr]);
  endtask

  initial begin
    logic [W-1:0] v;
    logic [A-1:0] a;
    int unsigned  r;

    Reset       = 1'b1;
    WriteEn     = 1'b0;
    DataAddress = '0;
    DataIn      = '0;
    #2;

    // Reset clear: preload, then pull Reset low between edges.
    dut.Core[63]  = 8'h5A;
    dut.Core[200] = 8'hFF;
    DataAddress   = 8'd63;
    #1;
    check_eq("preload_63", DataOut, 8'h5A);
    Reset = 1'b0;
    #1;
    model_clear();
    check_eq("rst_read_63", DataOut, 8'h00);
    read_at(8'd200, "rst_read_200");
    check_eq("rst_core_63", dut.Core[63], 8'h00);
    check_eq("rst_core_200", dut.Core[200], 8'h00);

    // Writes are ignored while Reset is held low.
    WriteEn     = 1'b1;
    DataAddress = 8'h0A;
    DataIn      = 8'h55;
    tick();
    check_eq("rst_blocks_write", DataOut, 8'h00);
    WriteEn = 1'b0;
    Reset   = 1'b1;
    #1;

    // Write then read back.
    WriteEn     = 1'b1;
    DataAddress = 8'h10;
    DataIn      = 8'hA5;
    tick();
    model[8'h10] = 8'hA5;
    WriteEn = 1'b0;
    #1;
    check_eq("wr_rd_10", DataOut, 8'hA5);
    read_at(8'h11, "wr_rd_11_untouched");

    // WriteEn gating.
    DataAddress = 8'h20;
    DataIn      = 8'h3C;
    repeat (5) tick();
    check_eq("we_gate_core32", dut.Core[32], 8'h00);

    // Backdoor persistence.
    dut.Core[61] = 8'd7;
    model[61] = 8'd7;
    dut.Core[62] = 8'd3;
    model[62] = 8'd3;
    dut.Core[63] = 8'h41;
    model[63] = 8'h41;
    for (int i = 64; i < 128; i++) begin
      v = W'($urandom);
      dut.Core[i] = v;
      model[i] = v;
    end
    repeat (40) tick();
    read_at(8'd61, "bd_61");
    read_at(8'd62, "bd_62");
    read_at(8'd63, "bd_63");
    for (int i = 64; i < 128; i++) read_at(A'(i), "bd_range");

    // Read-during-write, same address.
    dut.Core[5] = 8'h11;
    model[5]    = 8'h11;
    DataAddress = 8'd5;
    DataIn      = 8'h22;
    WriteEn     = 1'b1;
    #1;
    check_eq("rdw_before", DataOut, 8'h11);
    tick();
    model[5] = 8'h22;
    check_eq("rdw_after", DataOut, 8'h22);
    WriteEn = 1'b0;
    #1;

    // Randomized traffic against the reference contents.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 29);
      if (r == 0) begin
        Reset = 1'b0;
        #1;
        model_clear();
        check_eq("rnd_reset", DataOut, 8'h00);
        tick();
        Reset = 1'b1;
        #1;
      end else if (r == 1) begin
        a = A'($urandom);
        v = W'($urandom);
        dut.Core[a] = v;
        model[a] = v;
        read_at(a, "rnd_backdoor");
      end else begin
        a           = A'($urandom);
        v           = W'($urandom);
        WriteEn     = $urandom_range(0, 1) == 1;
        DataAddress = a;
        DataIn      = v;
        #1;
        check_eq("rnd_pre_edge", DataOut, model[a]);
        tick();
        if (WriteEn) model[a] = v;
        check_eq("rnd_post_edge", DataOut, model[a]);
        WriteEn = 1'b0;
        if (n % 8 == 0) read_at(A'($urandom), "rnd_probe");
      end
    end

    // Boundary address, then reset asserted mid-cycle with a write pending.
    WriteEn     = 1'b1;
    DataAddress = 8'd255;
    DataIn      = 8'h99;
    tick();
    model[255] = 8'h99;
    WriteEn = 1'b0;
    #1;
    check_eq("addr255_write", DataOut, 8'h99);
    WriteEn = 1'b1;
    DataIn  = 8'h77;
    #2;
    Reset = 1'b0;
    #1;
    model_clear();
    check_eq("midrst_immediate", DataOut, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("midrst_hold", DataOut, 8'h00);
    end
    check_eq("midrst_core255", dut.Core[255], 8'h00);
    Reset   = 1'b1;
    WriteEn = 1'b0;
    #1;
    check_eq("midrst_released", DataOut, 8'h00);
    read_at(8'h10, "midrst_other_addr");
    DataAddress = 8'd255;
    WriteEn     = 1'b1;
    tick();
    model[255] = 8'h77;
    WriteEn = 1'b0;
    #1;
    check_eq("post_rst_write", DataOut, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
